// File: rtl/mdu_pkg.sv
// Shared types and op-decode helpers for the RV32M multiply/divide sequencer.
// Pure declarations: no latency, no flow control.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mdu_state_t;

  function automatic logic is_div(input mdu_op_t op);
    return op[2];
  endfunction

  function automatic logic is_rem(input mdu_op_t op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

  function automatic logic is_signed_a(input mdu_op_t op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_signed_b(input mdu_op_t op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/mdu_sequencer.sv
// Bit-serial RV32M mul/div: done at WIDTH+2 cycles after accept (1 cycle for div-by-zero/overflow).
// Backpressure: stall holds the pipeline from the accept cycle until DONE; start is ignored unless IDLE.
module mdu_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       Funct3,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic             kill,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result
);
  import mdu_pkg::*;

  localparam int CW = $clog2(WIDTH);

  mdu_state_t         state, state_nxt;
  logic [CW-1:0]      cnt;
  mdu_op_t            op_q;
  logic [WIDTH-1:0]   am, bm;
  logic [2*WIDTH-1:0] acc;
  logic               neg_q, neg_rem_q;

  // Operand decode, valid while IDLE
  mdu_op_t          op_in;
  logic             sa, sb, accept, div_zero, ovf, shortcut;
  logic [WIDTH-1:0] a_mag, b_mag, short_res;

  assign op_in    = mdu_op_t'(Funct3);
  assign sa       = is_signed_a(op_in) & SrcA[WIDTH-1];
  assign sb       = is_signed_b(op_in) & SrcB[WIDTH-1];
  assign a_mag    = sa ? -SrcA : SrcA;
  assign b_mag    = sb ? -SrcB : SrcB;
  assign accept   = (state == IDLE) & start & ~kill;
  assign div_zero = is_div(op_in) && (SrcB == '0);
  assign ovf      = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                    (SrcA == {1'b1, {(WIDTH-1){1'b0}}}) && (SrcB == '1);
  assign shortcut = div_zero | ovf;

  always_comb begin
    short_res = '0;
    if (div_zero) short_res = is_rem(op_in) ? SrcA : '1;
    else          short_res = is_rem(op_in) ? '0 : SrcA;
  end

  // One iteration: multiply adds multiplicand on acc[0] then shifts right;
  // divide shifts left and keeps the trial subtraction when it does not borrow.
  logic [WIDTH:0]     mul_sum, div_part, div_diff;
  logic [2*WIDTH-1:0] mul_nxt, div_nxt;

  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, am} : '0);
  assign mul_nxt  = {mul_sum, acc[WIDTH-1:1]};
  assign div_part = acc[2*WIDTH-1:WIDTH-1];
  assign div_diff = div_part - {1'b0, bm};
  assign div_nxt  = div_diff[WIDTH] ? {div_part[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem, fix_res;

  assign prod = neg_q ? -acc : acc;
  assign quo  = acc[WIDTH-1:0];
  assign rem  = acc[2*WIDTH-1:WIDTH];

  always_comb begin
    fix_res = '0;
    case (op_q)
      OP_MUL:                       fix_res = prod[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:              fix_res = neg_q ? -quo : quo;
      default:                      fix_res = neg_rem_q ? -rem : rem;
    endcase
  end

  // State register plus registered busy/done
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == CALC) || (state_nxt == FIX);
      done  <= (state_nxt == DONE);
    end
  end

  always_comb begin
    state_nxt = state;
    if (kill) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (start) state_nxt = shortcut ? DONE : CALC;
        CALC: if (cnt == '0) state_nxt = FIX;
        FIX:  state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    stall = busy | accept;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q      <= OP_MUL;
      am        <= '0;
      bm        <= '0;
      acc       <= '0;
      cnt       <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      Result    <= '0;
    end else if (accept) begin
      op_q      <= op_in;
      am        <= a_mag;
      bm        <= b_mag;
      neg_q     <= sa ^ sb;
      neg_rem_q <= sa;
      cnt       <= CW'(WIDTH-1);
      acc       <= is_div(op_in) ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
      if (shortcut) Result <= short_res;
    end else if (!kill && state == CALC) begin
      acc <= is_div(op_q) ? div_nxt : mul_nxt;
      cnt <= cnt - CW'(1);
    end else if (!kill && state == FIX) begin
      Result <= fix_res;
    end
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Bench for mdu_sequencer: vector table plus hand sequences for kill, reset and DONE-cycle start.
module tb_mdu_sequencer;

  logic        clk, reset, start, kill;
  logic [2:0]  Funct3;
  logic [31:0] SrcA, SrcB, Result;
  logic        stall, busy, done;

  mdu_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .Funct3(Funct3),
    .SrcA(SrcA), .SrcB(SrcB), .kill(kill),
    .stall(stall), .busy(busy), .done(done), .Result(Result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    string       nm;
  } vec_t;

  vec_t        vq[$];
  logic [31:0] exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] last_exp;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input int lat, input string nm);
    vec_t v;
    v.f = f; v.a = a; v.b = b; v.exp = exp; v.lat = lat; v.nm = nm;
    vq.push_back(v);
  endtask

  // Called 1 time unit after an edge; returns in cycle 1 (just after the accepting edge).
  task automatic drive_start(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                             input string nm);
    start = 1'b1; Funct3 = f; SrcA = a; SrcB = b;
    #1;
    chk({nm, "_stall_c0"}, 32'(stall), 32'd1);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Starts in cycle 1; returns inside the DONE cycle (or after the timeout).
  task automatic wait_done(input int lat, input string nm);
    int c;
    bit seen;
    c = 1;
    seen = 1'b0;
    while (c <= 100 && !seen) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        chk({nm, "_stall_busy"}, 32'(stall), 32'd1);
        @(posedge clk); #1;
        c++;
      end
    end
    if (!seen) begin
      chk({nm, "_timeout"}, 32'd0, 32'd1);
    end else begin
      chk({nm, "_latency"}, 32'(c), 32'(lat));
      chk({nm, "_stall_done"}, 32'(stall), 32'd0);
    end
  endtask

  // Scoreboard: every done pulse consumes one expected result.
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        chk("result", Result, exp_q.pop_front());
      end
    end
  end

  initial begin
    reset = 1'b0; start = 1'b0; kill = 1'b0;
    Funct3 = 3'b000; SrcA = '0; SrcB = '0;

    add(3'b000, 32'd7,          32'd6,          32'd42,         34, "mul_7x6");
    add(3'b001, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000,  34, "mulh_m1xm1");
    add(3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  34, "mulhu_max");
    add(3'b010, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF,  34, "mulhsu_m1x2");
    add(3'b000, 32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFF1,  34, "mul_m3x5");
    add(3'b001, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000,  34, "mulh_min_sq");
    add(3'b011, 32'h8000_0000,  32'd4,          32'd2,          34, "mulhu_shift");
    add(3'b100, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  34, "div_m7_2");
    add(3'b110, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  34, "rem_m7_2");
    add(3'b100, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  34, "div_7_m2");
    add(3'b110, 32'd7,          32'hFFFF_FFFE,  32'd1,          34, "rem_7_m2");
    add(3'b101, 32'd100,        32'd7,          32'd14,         34, "divu_100_7");
    add(3'b111, 32'd100,        32'd7,          32'd2,          34, "remu_100_7");
    add(3'b101, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  34, "divu_max_1");
    add(3'b101, 32'd5,          32'd0,          32'hFFFF_FFFF,  1,  "divu_5_0");
    add(3'b111, 32'd5,          32'd0,          32'd5,          1,  "remu_5_0");
    add(3'b100, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  1,  "div_m5_0");
    add(3'b110, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  1,  "rem_m5_0");
    add(3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1,  "div_ovf");
    add(3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1,  "rem_ovf");

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",   32'(busy),  32'd0);
    chk("rst_done",   32'(done),  32'd0);
    chk("rst_stall",  32'(stall), 32'd0);
    chk("rst_result", Result,     32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Table: each op issued in the IDLE cycle right after the previous DONE.
    for (int i = 0; i < vq.size(); i++) begin
      exp_q.push_back(vq[i].exp);
      drive_start(vq[i].f, vq[i].a, vq[i].b, vq[i].nm);
      wait_done(vq[i].lat, vq[i].nm);
      @(posedge clk); #1;
      last_exp = vq[i].exp;
    end

    // start during DONE must be ignored
    exp_q.push_back(32'd25);
    drive_start(3'b000, 32'd5, 32'd5, "mul_5x5");
    wait_done(34, "mul_5x5");
    start = 1'b1; Funct3 = 3'b101; SrcA = 32'd9; SrcB = 32'd3;
    #1;
    chk("done_start_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("done_start_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk("done_start_idle", 32'(busy), 32'd0);
    last_exp = 32'd25;

    // kill in cycle 10 of a DIV, new MUL in cycle 11
    drive_start(3'b100, 32'd100, 32'd3, "div_killed");
    repeat (9) begin
      @(posedge clk); #1;
    end
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    chk("kill_busy",   32'(busy), 32'd0);
    chk("kill_done",   32'(done), 32'd0);
    chk("kill_result", Result,    last_exp);
    exp_q.push_back(32'd9);
    drive_start(3'b000, 32'd3, 32'd3, "mul_after_kill");
    wait_done(34, "mul_after_kill");
    @(posedge clk); #1;

    // asynchronous reset mid-CALC
    drive_start(3'b000, 32'd8, 32'd8, "mul_reset");
    repeat (4) begin
      @(posedge clk); #1;
    end
    reset = 1'b0;
    #1;
    chk("arst_busy",   32'(busy),  32'd0);
    chk("arst_stall",  32'(stall), 32'd0);
    chk("arst_done",   32'(done),  32'd0);
    chk("arst_result", Result,     32'd0);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back(32'd4);
    drive_start(3'b000, 32'd2, 32'd2, "mul_2x2");
    wait_done(34, "mul_2x2");
    @(posedge clk); #1;

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
